// File: rtl/axis_tx_frame_arbiter.sv
// Frame-locked arbiter sharing one AXI-Stream TX byte path between NUM_PORTS sources.
// Build option: AXIS_ARB_ROUND_ROBIN_EN selects round-robin; default is fixed priority (port 0 highest).
module axis_tx_frame_arbiter #(
  parameter  int AXI_DATA_WIDTH = 8,
  parameter  int NUM_PORTS      = 4,
  localparam int GNT_W          = $clog2(NUM_PORTS)
) (
  input  logic                                s_aclk,
  input  logic                                s_sresetn,
  input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                s_axis_tlast,
  input  logic [NUM_PORTS-1:0]                s_axis_tuser,
  output logic [NUM_PORTS-1:0]                s_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tuser,
  input  logic                                m_axis_trdy,
  output logic [GNT_W-1:0]                    gnt_idx,
  output logic                                busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                                   r_state;
  state_t                                   w_next_state;
  logic   [GNT_W-1:0]                       r_gnt_idx;
  logic   [GNT_W-1:0]                       w_win_idx;
  logic                                     w_win_vld;
  logic                                     w_last_beat;
  logic   [NUM_PORTS-1:0][AXI_DATA_WIDTH-1:0] w_tdata;

  assign w_tdata = s_axis_tdata;

`ifdef AXIS_ARB_ROUND_ROBIN_EN
  logic [GNT_W-1:0] r_rr_ptr;
  logic [GNT_W-1:0] w_rr_next;

  assign w_rr_next = (r_gnt_idx == GNT_W'(NUM_PORTS - 1)) ? '0 : r_gnt_idx + GNT_W'(1);

  // Search upward from the pointer with wrap; first requester wins.
  always_comb begin
    logic [GNT_W-1:0] idx;
    idx       = '0;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = GNT_W'((int'(r_rr_ptr) + k) % NUM_PORTS);
      if (!w_win_vld && s_axis_tvalid[idx]) begin
        w_win_vld = 1'b1;
        w_win_idx = idx;
      end
    end
  end

  always_ff @(posedge s_aclk or negedge s_sresetn) begin
    if (!s_sresetn) begin
      r_rr_ptr <= '0;
    end else if (r_state == XFER && w_last_beat) begin
      r_rr_ptr <= w_rr_next;
    end
  end
`else
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (!w_win_vld && s_axis_tvalid[k]) begin
        w_win_vld = 1'b1;
        w_win_idx = GNT_W'(k);
      end
    end
  end
`endif

  assign w_last_beat = m_axis_tvalid && m_axis_trdy && m_axis_tlast;

  always_ff @(posedge s_aclk or negedge s_sresetn) begin
    if (!s_sresetn) begin
      r_state   <= IDLE;
      r_gnt_idx <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && w_win_vld) begin
        r_gnt_idx <= w_win_idx;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_win_vld)   w_next_state = XFER;
      XFER: if (w_last_beat) w_next_state = IDLE;
      default:               w_next_state = IDLE;
    endcase
  end

  // Pure pass-through from the granted port; nothing is buffered here.
  always_comb begin
    s_axis_trdy   = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    if (r_state == XFER) begin
      m_axis_tdata             = w_tdata[r_gnt_idx];
      m_axis_tvalid            = s_axis_tvalid[r_gnt_idx];
      m_axis_tlast             = s_axis_tlast[r_gnt_idx];
      m_axis_tuser             = s_axis_tuser[r_gnt_idx];
      s_axis_trdy[r_gnt_idx]   = m_axis_trdy;
    end
  end

  assign gnt_idx = r_gnt_idx;
  assign busy    = (r_state == XFER);

endmodule

// File: tb/tb_axis_tx_frame_arbiter.sv
// Scoreboard bench for axis_tx_frame_arbiter: per-port source queues, per-port expected beats, expected grant order.
module tb_axis_tx_frame_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tuser;
  logic [N-1:0]   s_trdy;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tuser;
  logic           m_trdy;
  logic [1:0]     gnt;
  logic           busy;

  always #5 clk = ~clk;

  axis_tx_frame_arbiter #(.AXI_DATA_WIDTH(W), .NUM_PORTS(N)) dut (
    .s_aclk        (clk),
    .s_sresetn     (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_trdy   (s_trdy),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_trdy   (m_trdy),
    .gnt_idx       (gnt),
    .busy          (busy)
  );

  // Beat encoding {tuser, tlast, tdata}
  logic [9:0] src_q [N][$];
  logic [9:0] exp_q [N][$];
  int         exp_gnt [$];
  int         drop_cnt [N];
  logic       trdy_pat [$];

  int         n_cmp = 0;
  int         n_err = 0;
  logic       prev_busy;
  logic       prev_tlast_acc;
  logic [1:0] cur_gnt;
  int         busy_len;
  int         max_busy_len;
  int         frames_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      if (src_q[p].size() > 0 && drop_cnt[p] == 0) begin
        s_tvalid[p]       = 1'b1;
        s_tdata[p*W +: W] = src_q[p][0][7:0];
        s_tlast[p]        = src_q[p][0][8];
        s_tuser[p]        = src_q[p][0][9];
      end else begin
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
        s_tuser[p]  = 1'b0;
      end
      if (drop_cnt[p] > 0) drop_cnt[p]--;
    end
  endtask

  task automatic load(input int p, input logic [7:0] base, input int len, input logic user);
    logic [9:0] b;
    for (int i = 0; i < len; i++) begin
      b = {user && (i == len - 1), (i == len - 1), base + 8'(i)};
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
    drive_inputs();
  endtask

  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    if (busy && !prev_busy) begin
      if (exp_gnt.size() == 0) check_eq("gnt_extra", 32'(exp_gnt.size()), 1);
      else                     check_eq("gnt_order", gnt, exp_gnt.pop_front());
      cur_gnt  = gnt;
      busy_len = 0;
    end
    if (busy && prev_busy) check_eq("gnt_held", gnt, cur_gnt);
    if (busy) begin
      busy_len++;
      check_eq("trdy_others", s_trdy & ~(4'b0001 << gnt), 0);
    end else begin
      check_eq("idle_mvalid", {m_tvalid, s_trdy}, 0);
    end
    if (prev_tlast_acc) check_eq("bubble", busy, 0);
    if (!busy && prev_busy) begin
      frames_done++;
      if (busy_len > max_busy_len) max_busy_len = busy_len;
    end
    acc = s_tvalid & s_trdy;
    if (m_tvalid && m_trdy) begin
      if (exp_q[gnt].size() == 0) check_eq("beat_extra", 32'(exp_q[gnt].size()), 1);
      else check_eq("beat", {m_tuser, m_tlast, m_tdata}, exp_q[gnt].pop_front());
    end
    prev_tlast_acc = m_tvalid && m_trdy && m_tlast;
    prev_busy      = busy;
    @(posedge clk);
    #1;
    for (int p = 0; p < N; p++) if (acc[p]) void'(src_q[p].pop_front());
    m_trdy = (trdy_pat.size() > 0) ? trdy_pat.pop_front() : 1'b1;
    drive_inputs();
  endtask

  function automatic int pending();
    int s = 0;
    for (int p = 0; p < N; p++) s += src_q[p].size();
    return s;
  endfunction

  task automatic run_until_idle(input int max_cycles);
    int  left;
    bit  done = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (pending() == 0 && !busy) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) check_eq("timeout", 1, 0);
    tick();
    left = exp_gnt.size();
    for (int p = 0; p < N; p++) left += exp_q[p].size();
    check_eq("exp_left", left, 0);
  endtask

  task automatic clear_all();
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      drop_cnt[p] = 0;
    end
    exp_gnt.delete();
    trdy_pat.delete();
    drive_inputs();
    prev_busy      = 1'b0;
    prev_tlast_acc = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_trdy = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
    for (int p = 0; p < N; p++) drop_cnt[p] = 0;
    rst_n = 1'b0;
    m_trdy = 1'b1;
    busy_len = 0; max_busy_len = 0; frames_done = 0; cur_gnt = '0;
    prev_busy = 1'b0; prev_tlast_acc = 1'b0;
    #12;
    check_eq("rst_state", {busy, gnt, m_tvalid, m_tlast, m_tuser, m_tdata, s_trdy}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single source, port 2
    exp_gnt.push_back(2);
    load(2, 8'h11, 5, 1'b0);
    tick();
    check_eq("lat_busy", busy, 1);
    check_eq("lat_gnt", gnt, 2);
    run_until_idle(40);

    // Contention 0,1,3 from a clean pointer
    do_reset();
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(3);
    load(0, 8'hA0, 3, 1'b0);
    load(1, 8'hB0, 3, 1'b0);
    load(3, 8'hD0, 3, 1'b0);
    run_until_idle(60);
    exp_gnt.push_back(0); exp_gnt.push_back(3);
    load(3, 8'hE0, 2, 1'b0);
    load(0, 8'hF0, 2, 1'b0);
    run_until_idle(40);

    // Port 0 re-requests continuously while port 1 waits
`ifdef AXIS_ARB_ROUND_ROBIN_EN
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(0);
`else
    exp_gnt.push_back(0); exp_gnt.push_back(0); exp_gnt.push_back(0); exp_gnt.push_back(1);
`endif
    load(0, 8'h30, 2, 1'b0);
    load(0, 8'h40, 2, 1'b0);
    load(0, 8'h50, 2, 1'b0);
    load(1, 8'h60, 2, 1'b0);
    run_until_idle(60);

    // Backpressure and a 2-cycle tvalid gap on port 1 while port 2 waits; tuser on last beat
    for (int i = 0; i < 6; i++) begin
      trdy_pat.push_back(1'b1);
      trdy_pat.push_back(1'b0);
    end
    exp_gnt.push_back(1); exp_gnt.push_back(2);
    load(1, 8'h70, 4, 1'b1);
    load(2, 8'h80, 3, 1'b0);
    tick(); tick(); tick();
    drop_cnt[1] = 2;
    run_until_idle(60);

    // Reset mid-frame after byte 2 of 6
    exp_gnt.push_back(2);
    load(2, 8'h90, 6, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (exp_q[2].size() <= 4) break;
      tick();
    end
    check_eq("mid_beats", 32'(exp_q[2].size()), 4);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", {busy, gnt, m_tvalid, m_tlast, m_tuser, m_tdata, s_trdy}, 0);
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_gnt.push_back(1); exp_gnt.push_back(3);
    load(3, 8'hC0, 2, 1'b0);
    load(1, 8'hC8, 2, 1'b0);
    run_until_idle(40);

    // Single-beat frames
    frames_done = 0;
    max_busy_len = 0;
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    src_q[0].push_back({1'b0, 1'b1, 8'h5A}); exp_q[0].push_back({1'b0, 1'b1, 8'h5A});
    src_q[1].push_back({1'b0, 1'b1, 8'hA5}); exp_q[1].push_back({1'b0, 1'b1, 8'hA5});
    drive_inputs();
    run_until_idle(20);
    check_eq("sb_frames", frames_done, 2);
    check_eq("sb_busy_len", max_busy_len, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
